// File: rtl/pong_draw_pkg.sv
// pong_draw_pkg: shared constants and arbiter state encoding for the pong draw path.
package pong_draw_pkg;
  localparam int COORD_W = 9;
  localparam int COLOR_W = 3;
  localparam int NUM_REQ = 3;
  localparam logic [1:0] GRANT_NONE = 2'd3;
  typedef enum logic [2:0] {IDLE, ERASE, WAIT_ERASE, DRAW, WAIT_DRAW, ACK} arb_state_e;
endpackage

// File: rtl/draw_rr_pick.sv
// draw_rr_pick: combinational 3-way round-robin selector starting the scan at rr_ptr.
module draw_rr_pick
  import pong_draw_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [1:0]         rr_ptr,
  output logic               pick_valid,
  output logic [1:0]         pick_idx
);
  logic [1:0] i1, i2;
  always_comb begin
    i1 = (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    i2 = (i1 == 2'd2) ? 2'd0 : i1 + 2'd1;
    pick_valid = |req_valid;
    pick_idx = req_valid[rr_ptr] ? rr_ptr : req_valid[i1] ? i1 : i2;
  end
endmodule

// File: rtl/draw_arbiter.sv
// draw_arbiter: shares the rectangle drawer between paddles and ball (erase old, draw new, ack).
module draw_arbiter
  import pong_draw_pkg::*;
#(
  parameter logic [COLOR_W-1:0] BG_COLOR = 3'b000,
  parameter logic [COORD_W-1:0] REQ0_W   = 9'd10,
  parameter logic [COORD_W-1:0] REQ0_H   = 9'd48,
  parameter logic [COORD_W-1:0] REQ1_W   = 9'd10,
  parameter logic [COORD_W-1:0] REQ1_H   = 9'd48,
  parameter logic [COORD_W-1:0] REQ2_W   = 9'd4,
  parameter logic [COORD_W-1:0] REQ2_H   = 9'd4,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'd200000
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*COORD_W-1:0]   req_x,
  input  logic [NUM_REQ*COORD_W-1:0]   req_y,
  input  logic [NUM_REQ*COLOR_W-1:0]   req_color,
  output logic                         drw_start,
  output logic [COORD_W-1:0]           drw_x,
  output logic [COORD_W-1:0]           drw_y,
  output logic [COORD_W-1:0]           drw_w,
  output logic [COORD_W-1:0]           drw_h,
  output logic [COLOR_W-1:0]           drw_color,
  input  logic                         drw_done,
  output logic [1:0]                   grant
`ifdef DRAW_ARB_TIMEOUT_EN
  , output logic                       drw_timeout
`endif
);
  arb_state_e state_q, state_d;
  logic [1:0] g_q, g_d, rr_ptr_q;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COLOR_W-1:0] cur_c_q, cur_c_d;
  logic [NUM_REQ-1:0] prev_valid_q;
  logic [NUM_REQ-1:0][COORD_W-1:0] prev_x_q, prev_y_q;
  logic pick_valid, erase_ph, draw_ph, timeout_hit;
  logic [1:0] pick_idx;
  draw_rr_pick u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .pick_valid(pick_valid),
    .pick_idx  (pick_idx)
  );
`ifdef DRAW_ARB_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        to_q;
  assign timeout_hit = (erase_ph || draw_ph) && !drw_start && (cnt_q + 32'd1 == TIMEOUT_CYCLES);
  assign drw_timeout = to_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= drw_start ? 32'd1 : (erase_ph || draw_ph) ? cnt_q + 32'd1 : cnt_q;
      to_q  <= to_q | (timeout_hit & ~drw_done);
    end
`else
  assign timeout_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    cur_c_d = cur_c_q;
    case (state_q)
      IDLE: if (pick_valid) begin
        g_d     = pick_idx;
        cur_x_d = req_x[COORD_W*pick_idx +: COORD_W];
        cur_y_d = req_y[COORD_W*pick_idx +: COORD_W];
        cur_c_d = req_color[COLOR_W*pick_idx +: COLOR_W];
        state_d = prev_valid_q[pick_idx] ? ERASE : DRAW;
      end
      ERASE:      state_d = WAIT_ERASE;
      WAIT_ERASE: state_d = timeout_hit ? ACK : drw_done ? DRAW : WAIT_ERASE;
      DRAW:       state_d = WAIT_DRAW;
      WAIT_DRAW:  state_d = (timeout_hit || drw_done) ? ACK : WAIT_DRAW;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    erase_ph  = (state_q == ERASE) || (state_q == WAIT_ERASE);
    draw_ph   = (state_q == DRAW) || (state_q == WAIT_DRAW);
    drw_start = (state_q == ERASE) || (state_q == DRAW);
    drw_x     = erase_ph ? prev_x_q[g_q] : draw_ph ? cur_x_q : '0;
    drw_y     = erase_ph ? prev_y_q[g_q] : draw_ph ? cur_y_q : '0;
    drw_w     = !(erase_ph || draw_ph) ? '0 : (g_q == 2'd0) ? REQ0_W : (g_q == 2'd1) ? REQ1_W : REQ2_W;
    drw_h     = !(erase_ph || draw_ph) ? '0 : (g_q == 2'd0) ? REQ0_H : (g_q == 2'd1) ? REQ1_H : REQ2_H;
    drw_color = draw_ph ? cur_c_q : BG_COLOR;
    req_ready = (state_q == ACK) ? 3'b001 << g_q : '0;
    grant     = (state_q == IDLE) ? GRANT_NONE : g_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q      <= IDLE;
      g_q          <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      cur_c_q      <= '0;
      rr_ptr_q     <= '0;
      prev_valid_q <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      cur_c_q <= cur_c_d;
      if (state_q == ACK) begin
        prev_x_q[g_q]     <= cur_x_q;
        prev_y_q[g_q]     <= cur_y_q;
        prev_valid_q[g_q] <= 1'b1;
        rr_ptr_q          <= (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;
      end
    end
endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Shares the single rectangle screen drawer between three location processors: req 0 = left paddle, req 1 = right paddle, req 2 = ball.
- Per granted request, the block first erases the requester's previous rectangle in background colour, then draws the new rectangle at the requester's current position and colour.
- It then pulses that requester's ready, which releases the requester to its next position update.
- It sits between the location processors' m_valid/m_ready interfaces and the drawer's start/done interface.

Parameters:
- NUM_REQ, 3, number of requesters; fixed at 3 for this game.
- BG_COLOR, 3'b000, colour used for the erase pass.
- REQ0_W, 9'd10, left paddle width. REQ0_H, 9'd48, left paddle height.
- REQ1_W, 9'd10, right paddle width. REQ1_H, 9'd48, right paddle height.
- REQ2_W, 9'd4, ball width. REQ2_H, 9'd4, ball height.
- TIMEOUT_CYCLES, 32'd200000, drawer watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  3  m_valid from each location processor; bit i = requester i.
- req_ready  out  3  m_ready to each location processor; bit i = requester i.
- req_x  in  27  box_x per requester, 9 bits each; requester i at [9i+8:9i].
- req_y  in  27  box_y per requester, same packing.
- req_color  in  9  out_color per requester, 3 bits each; requester i at [3i+2:3i].
- drw_start  out  1  one-cycle pulse; launches a drawer fill of the rectangle given on drw_*.
- drw_x  out  9  rectangle left edge.
- drw_y  out  9  rectangle top edge.
- drw_w  out  9  rectangle width.
- drw_h  out  9  rectangle height.
- drw_color  out  3  fill colour.
- drw_done  in  1  one-cycle pulse from the drawer when the fill completes.
- grant  out  2  index of the requester currently being served; 2'd3 when idle.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, req_ready=0, drw_start=0, drw_x/y/w/h=0, drw_color=BG_COLOR, grant=2'd3.
  - rr_ptr=0; prev_valid[2:0]=0; prev_x/prev_y all 0.
- Reset mid-operation abandons any fill in progress. The drawer's outstanding done is ignored because the FSM is back in IDLE.
- States:
  - IDLE: pick the first requester with req_valid=1, scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). On a pick, latch g, cur_x=req_x[g], cur_y=req_y[g], cur_c=req_color[g]; set grant=g. Go to ERASE if prev_valid[g]=1, else DRAW. If nothing is valid, stay in IDLE.
  - ERASE: drive drw_x/y=prev_x/prev_y[g], drw_w/h=REQg_W/H, drw_color=BG_COLOR; pulse drw_start one cycle; go to WAIT_ERASE.
  - WAIT_ERASE: hold drw_* stable; on drw_done go to DRAW.
  - DRAW: drive drw_x/y=cur_x/cur_y, drw_w/h=REQg_W/H, drw_color=cur_c; pulse drw_start; go to WAIT_DRAW.
  - WAIT_DRAW: hold drw_*; on drw_done go to ACK.
  - ACK: req_ready[g]=1 for exactly this cycle. prev_x/prev_y[g]<=cur_x/cur_y, prev_valid[g]<=1, rr_ptr<=(g==2)?0:g+1. Go to IDLE; grant returns to 3 on the IDLE cycle.
- Timing and handshakes:
  - Coordinates are latched at grant. Input changes during service are ignored.
  - Minimum service: 1 IDLE + 2 + 2 + 1 cycles plus drawer latency. An arbitration decision is possible every IDLE cycle.
  - req_ready is never asserted for a non-granted requester; at most one bit of req_ready is high at any time.
  - drw_done arriving outside WAIT_ERASE/WAIT_DRAW is ignored.
  - drw_done arriving in the same cycle as drw_start is not possible; the drawer responds at least one cycle later.
- Simultaneous requests are resolved by rr_ptr only; no requester waits more than 2 services.
- Width rules: all coordinates 9-bit unsigned, passed through unmodified; no clipping in this block.

Optional Feature:
- DRAW_ARB_TIMEOUT_EN defined:
  - A 32-bit counter clears on each drw_start and increments in WAIT_ERASE/WAIT_DRAW.
  - On reaching TIMEOUT_CYCLES, the FSM goes directly to ACK: the requester is released and prev is updated.
  - Sticky output drw_timeout (1 bit, reset 0) is set.
- DRAW_ARB_TIMEOUT_EN undefined: no counter, no drw_timeout port; the wait states block indefinitely until drw_done.

Decomposition:
- Package pong_draw_pkg:
  - arbiter state encoding (IDLE, ERASE, WAIT_ERASE, DRAW, WAIT_DRAW, ACK);
  - COORD_W=9, COLOR_W=3, NUM_REQ=3;
  - GRANT_NONE=2'd3.
- Sub-module draw_rr_pick: combinational 3-way round-robin selector taking req_valid and rr_ptr, returning pick_valid and pick_idx. The FSM and the prev registers stay in draw_arbiter.

Test Plan:
- Drawer model asserts done 5 cycles after start.
- First draw: after reset, req_valid=3'b100, ball at (160,120), colour 3'b111. Expect grant=2, a single drw_start with (160,120,4,4,3'b111) and no erase, then req_ready=3'b100 for one cycle.
- Erase then draw: ball moves to (161,121) and re-requests. Expect start 1 at (160,120,4,4,BG_COLOR), then start 2 at (161,121,4,4,3'b111), then ready.
- Round-robin: req_valid=3'b111 held, rr_ptr=0. Expect grant order 0,1,2,0; no requester is granted twice before the others.
- Input stability: change req_x[0] from 0 to 9 mid-WAIT_DRAW. Expect drw_x stays 0 until ACK; prev_x[0]=0.
- Reset in WAIT_ERASE: assert reset_n=0, then drive a stray drw_done after release. Expect IDLE, outputs at reset values, and no req_ready.
- With DRAW_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, drawer never responds. Expect ACK 16 cycles after drw_start, drw_timeout=1, and req_ready pulsed.
